// File: rtl/mult8_seq_4x4_ctrl.sv
// Sequential 8x8 unsigned multiplier built around one external 4x4 multiplier.
// Four nibble partial products are issued in turn, then shifted and summed into a 16-bit result.
module mult8_seq_4x4_ctrl #(
    parameter bit REG_PROD = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_step;
    logic        r_phase;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [7:0]  r_prod;
    logic [3:0]  r_mul_a;
    logic [3:0]  r_mul_b;
    logic        r_out_valid;
    logic [15:0] r_out_p;
    logic        r_in_ready;
    logic        r_busy;

    logic [7:0]  w_prod;
    logic [15:0] w_term;
    logic [15:0] w_acc_next;
    logic [1:0]  w_nxt_step;
    logic        w_acc_en;

    // With REG_PROD the first cycle of a step only captures mul_p; the second accumulates it.
    assign w_prod     = REG_PROD ? r_prod : mul_p;
    assign w_acc_en   = !REG_PROD || r_phase;
    assign w_nxt_step = r_step + 2'd1;
    assign w_acc_next = r_acc + w_term;

    always_comb begin
        w_term = 16'd0;
        case (r_step)
            2'd0:    w_term = {8'd0, w_prod};
            2'd1,
            2'd2:    w_term = {4'd0, w_prod, 4'd0};
            default: w_term = {w_prod, 8'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= 2'd0;
            r_phase     <= 1'b0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_acc       <= 16'd0;
            r_prod      <= 8'd0;
            r_mul_a     <= 4'd0;
            r_mul_b     <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_p     <= 16'd0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_acc      <= 16'd0;
                        r_step     <= 2'd0;
                        r_phase    <= 1'b0;
                        r_mul_a    <= in_a[3:0];
                        r_mul_b    <= in_b[3:0];
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_prod <= mul_p;
                    if (!w_acc_en) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        r_acc   <= w_acc_next;
                        if (r_step == 2'd3) begin
                            r_out_p     <= w_acc_next;
                            r_out_valid <= 1'b1;
                            r_mul_a     <= 4'd0;
                            r_mul_b     <= 4'd0;
                            r_state     <= S_DONE;
                        end else begin
                            // Step order: (alo,blo) (alo,bhi) (ahi,blo) (ahi,bhi)
                            r_step  <= w_nxt_step;
                            r_mul_a <= w_nxt_step[1] ? r_a[7:4] : r_a[3:0];
                            r_mul_b <= w_nxt_step[0] ? r_b[7:4] : r_b[3:0];
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign busy      = r_busy;

endmodule
